// File: rtl/lzrw_job_arbiter.sv
// Round-robin scheduler feeding one compressor_top: streams NBEATS beats per job, waits Done, then holds comp_reset CLEARCYC cycles.
// No backpressure on the beat stream; LZRW_WDOG_EN adds a Done watchdog that aborts the job via job_err.
module lzrw_job_arbiter #(
    parameter int NREQ       = 2,
    parameter int STRINGSIZE = 350,
    parameter int BEATBYTES  = 16,
    parameter int CLEARCYC   = 2,
    parameter int WDOG_CYC   = 1024
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NREQ-1:0]               req,
    input  logic [NREQ*8*BEATBYTES-1:0]   beat_data,
    output logic [NREQ-1:0]               gnt,
    output logic [NREQ-1:0]               beat_ack,
    output logic                          valid,
    output logic [8*BEATBYTES-1:0]        CurByte,
    input  logic                          Done,
    output logic                          comp_reset,
    output logic [NREQ-1:0]               job_done,
    output logic [NREQ-1:0]               job_err,
    output logic                          busy
);

    localparam int NBEATS = (STRINGSIZE + BEATBYTES - 1) / BEATBYTES;
    localparam int BW     = 8 * BEATBYTES;
    localparam int CW     = $clog2(NBEATS + 1);
    localparam int IW     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int KW     = $clog2(CLEARCYC + 1);

    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("lzrw_job_arbiter: NREQ must be 2..8");
    end
    if (CLEARCYC < 1 || WDOG_CYC < 1) begin : g_bad_cyc
        $error("lzrw_job_arbiter: CLEARCYC and WDOG_CYC must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, STREAM, WAIT, CLEAR} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [KW-1:0]   clr_cnt_q, clr_cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [BW-1:0]   curbyte_q, curbyte_d;
    logic [BW-1:0]   cur_beat;
    logic [NREQ-1:0] job_err_w;
    logic [IW-1:0]   pick;
    logic            pick_vld;
    logic [IW:0]     idx;

`ifdef LZRW_WDOG_EN
    localparam int WW = $clog2(WDOG_CYC + 1);
    logic [WW-1:0] wdog_q, wdog_d;
`endif

    // First requesting index at or above the rr pointer, wrapping at NREQ.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        idx      = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (IW+1)'(rr_q) + (IW+1)'(i);
            if (idx >= (IW+1)'(NREQ)) begin
                idx = idx - (IW+1)'(NREQ);
            end
            if (!pick_vld && req[idx[IW-1:0]]) begin
                pick     = idx[IW-1:0];
                pick_vld = 1'b1;
            end
        end
    end

    assign cur_beat = beat_data[owner_q*BW +: BW];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_q       <= '0;
            beat_cnt_q <= '0;
            clr_cnt_q  <= '0;
            gnt_q      <= '0;
            curbyte_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_q       <= rr_d;
            beat_cnt_q <= beat_cnt_d;
            clr_cnt_q  <= clr_cnt_d;
            gnt_q      <= gnt_d;
            curbyte_q  <= curbyte_d;
        end
    end

`ifdef LZRW_WDOG_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_d       = rr_q;
        beat_cnt_d = beat_cnt_q;
        clr_cnt_d  = clr_cnt_q;
        gnt_d      = gnt_q;
        curbyte_d  = curbyte_q;
        valid      = 1'b0;
        beat_ack   = '0;
        job_done   = '0;
        job_err_w  = '0;
        CurByte    = curbyte_q;
`ifdef LZRW_WDOG_EN
        wdog_d     = wdog_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    owner_d       = pick;
                    gnt_d         = '0;
                    gnt_d[pick]   = 1'b1;
                    beat_cnt_d    = '0;
                    state_d       = STREAM;
                end
            end
            STREAM: begin
                // CurByte is live from the owner's buffer; the register keeps it stable once streaming stops.
                valid      = 1'b1;
                CurByte    = cur_beat;
                curbyte_d  = cur_beat;
                beat_ack   = gnt_q;
                beat_cnt_d = beat_cnt_q + CW'(1);
                if (beat_cnt_q == CW'(NBEATS - 1)) begin
                    state_d = WAIT;
`ifdef LZRW_WDOG_EN
                    wdog_d  = '0;
`endif
                end
            end
            WAIT: begin
                if (Done) begin
                    job_done  = gnt_q;
                    clr_cnt_d = '0;
                    state_d   = CLEAR;
                end
`ifdef LZRW_WDOG_EN
                else if (wdog_q == WW'(WDOG_CYC - 1)) begin
                    job_err_w = gnt_q;
                    clr_cnt_d = '0;
                    state_d   = CLEAR;
                end else begin
                    wdog_d = wdog_q + WW'(1);
                end
`endif
            end
            CLEAR: begin
                if (clr_cnt_q == KW'(CLEARCYC - 1)) begin
                    state_d    = IDLE;
                    gnt_d      = '0;
                    beat_cnt_d = '0;
                    clr_cnt_d  = '0;
                    rr_d       = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);
                end else begin
                    clr_cnt_d = clr_cnt_q + KW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef LZRW_WDOG_EN
    assign job_err = job_err_w;
`else
    assign job_err = '0;
`endif

    assign gnt        = gnt_q;
    assign busy       = (state_q != IDLE);
    assign comp_reset = reset | (state_q == CLEAR);

endmodule

// File: tb/tb_lzrw_job_arbiter.sv
// Scoreboarded bench: requester/compressor behavioural models drive the arbiter, a monitor checks every output cycle.
module tb_lzrw_job_arbiter;

    localparam int NREQ = 2;
    localparam int NB   = 22;
    localparam int CLR  = 2;
    localparam int BW   = 128;

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic [NREQ-1:0]      req;
    logic [NREQ*BW-1:0]   beat_data;
    logic [NREQ-1:0]      gnt, beat_ack, job_done, job_err;
    logic                 valid, Done, comp_reset, busy;
    logic [BW-1:0]        CurByte;

    lzrw_job_arbiter #(
        .NREQ(NREQ), .STRINGSIZE(350), .BEATBYTES(16), .CLEARCYC(CLR), .WDOG_CYC(64)
    ) dut (
        .clock(clock), .reset(reset), .req(req), .beat_data(beat_data),
        .gnt(gnt), .beat_ack(beat_ack), .valid(valid), .CurByte(CurByte),
        .Done(Done), .comp_reset(comp_reset), .job_done(job_done),
        .job_err(job_err), .busy(busy)
    );

    initial forever #5 clock = ~clock;

    typedef struct { int own; logic [BW-1:0] dat; } beat_t;
    typedef struct { int own; int beat_end; } job_t;

    beat_t beat_q[$];
    job_t  done_q[$];
    int checks = 0;
    int errors = 0;
    int pend[NREQ];
    int dcnt[NREQ];
    int bidx[NREQ];
    int mjob[NREQ];
    int rr_m = 0;
    int pushed = 0;
    int popped = 0;
    int vrun = 0;
    int gap = -1;
    int crun = 0;
    int done_delay = 10;
    int done_early = 0;
    logic [31:0] salt;

    function automatic logic [BW-1:0] bd(int r, int j, int k);
        logic [31:0] a;
        a = salt ^ 32'(r * 7919 + j * 104729);
        return {a + 32'(k), a ^ (32'(k) * 32'h9E3779B9), ~a - 32'(k), (32'(r) << 24) | (32'(j) << 8) | 32'(k)};
    endfunction

    task automatic chk(string nm, logic [BW-1:0] act, logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: each job goes to the first requester with work left, scanning up from the last owner + 1.
    task automatic plan(int n0, int n1);
        int pm[NREQ];
        int o;
        pm[0] = n0;
        pm[1] = n1;
        pend[0] += n0;
        pend[1] += n1;
        while (pm[0] + pm[1] > 0) begin
            o = -1;
            for (int i = 0; i < NREQ; i++) begin
                if (o < 0 && pm[(rr_m + i) % NREQ] > 0) o = (rr_m + i) % NREQ;
            end
            for (int k = 0; k < NB; k++) begin
                beat_q.push_back('{own: o, dat: bd(o, mjob[o], k)});
                pushed++;
            end
            done_q.push_back('{own: o, beat_end: pushed});
            mjob[o]++;
            pm[o]--;
            rr_m = (o + 1) % NREQ;
        end
    endtask

    task automatic rst_on();
        reset = 1'b1;
        #1;
        beat_q.delete();
        done_q.delete();
        pushed = 0;
        rr_m = 0;
        for (int r = 0; r < NREQ; r++) begin
            pend[r] = dcnt[r];
            mjob[r] = dcnt[r];
        end
    endtask

    task automatic rst_release(int cyc);
        repeat (cyc) begin
            @(negedge clock);
            chk("comp_reset_during_reset", BW'(comp_reset), BW'(1));
        end
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic wait_idle(string nm, int budget);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            @(negedge clock);
            if (done_q.size() == 0 && beat_q.size() == 0 && !busy) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: timeout, %0d jobs still outstanding, required 0", nm, done_q.size());
        end
    endtask

    // Requester buffers: beat pointer advances after beat_ack, rewinds while not granted.
    initial begin
        logic [NREQ-1:0] ack, g, jd;
        req = '0;
        beat_data = '0;
        forever begin
            @(negedge clock);
            ack = beat_ack;
            g   = gnt;
            jd  = job_done;
            @(posedge clock);
            #1;
            for (int r = 0; r < NREQ; r++) begin
                if (!g[r]) bidx[r] = 0;
                else if (ack[r]) bidx[r]++;
                if (jd[r]) dcnt[r]++;
                req[r] = (pend[r] > dcnt[r]);
                beat_data[r*BW +: BW] = bd(r, dcnt[r], bidx[r]);
            end
        end
    end

    // Compressor stand-in: Done some cycles after the stream ends, optional stray pulse mid-stream.
    initial begin
        int vc, wc;
        logic nd;
        vc = 0;
        wc = -1;
        Done = 1'b0;
        forever begin
            @(negedge clock);
            nd = 1'b0;
            if (reset) begin
                vc = 0;
                wc = -1;
            end else if (valid) begin
                vc++;
                if (done_early != 0 && vc == 5) nd = 1'b1;
            end else begin
                if (vc != 0) begin
                    vc = 0;
                    wc = (done_delay == -2) ? int'($urandom_range(0, 20)) : done_delay;
                end
                if (wc == 0) nd = 1'b1;
                if (wc >= 0) wc--;
            end
            @(posedge clock);
            #1 Done = nd;
        end
    end

    // Monitor / scoreboard.
    initial begin
        beat_t e;
        job_t  j;
        forever begin
            @(negedge clock);
            if (reset) begin
                vrun = 0;
                gap = -1;
                crun = 0;
                popped = 0;
            end else begin
                if (valid) begin
                    if (beat_q.size() == 0) begin
                        chk("unexpected_beat", BW'(1), BW'(0));
                    end else begin
                        e = beat_q.pop_front();
                        popped++;
                        chk("gnt_owner", BW'(gnt), BW'(NREQ'(1) << e.own));
                        chk("beat_ack", BW'(beat_ack), BW'(NREQ'(1) << e.own));
                        chk("CurByte", CurByte, e.dat);
                    end
                    if (gap >= 0) begin
                        chk("job_gap", BW'(gap), BW'(CLR + 1));
                        gap = -1;
                    end
                    vrun++;
                end else begin
                    if (vrun != 0) begin
                        chk("nbeats", BW'(vrun), BW'(NB));
                        vrun = 0;
                    end
                    chk("beat_ack_idle", BW'(beat_ack), BW'(0));
                    if (gap >= 0) gap++;
                end
                if (job_done != '0) begin
                    if (done_q.size() == 0) begin
                        chk("unexpected_job_done", BW'(job_done), BW'(0));
                    end else begin
                        j = done_q.pop_front();
                        chk("job_done", BW'(job_done), BW'(NREQ'(1) << j.own));
                        chk("done_after_beats", BW'(popped), BW'(j.beat_end));
                        if (beat_q.size() != 0) gap = 0;
                    end
                end
                chk("job_err", BW'(job_err), BW'(0));
                if (comp_reset) begin
                    crun++;
                end else if (crun != 0) begin
                    chk("clear_len", BW'(crun), BW'(CLR));
                    crun = 0;
                end
            end
        end
    end

    initial begin
        bit hit;
        salt = $urandom;
        #1 reset = 1'b1;
        #1;
        chk("rst_gnt", BW'(gnt), BW'(0));
        chk("rst_beat_ack", BW'(beat_ack), BW'(0));
        chk("rst_valid", BW'(valid), BW'(0));
        chk("rst_CurByte", CurByte, BW'(0));
        chk("rst_job_done", BW'(job_done), BW'(0));
        chk("rst_job_err", BW'(job_err), BW'(0));
        chk("rst_busy", BW'(busy), BW'(0));
        chk("rst_comp_reset", BW'(comp_reset), BW'(1));
        rst_release(3);

        // Single job, late Done.
        done_delay = 40;
        plan(1, 0);
        wait_idle("single_job", 400);
        chk("single_gnt_end", BW'(gnt), BW'(0));
        chk("single_comp_reset_end", BW'(comp_reset), BW'(0));

        // Both requesting right out of reset.
        rst_on();
        rst_release(2);
        done_delay = 5;
        plan(1, 1);
        wait_idle("both_req", 600);

        // Four back-to-back jobs alternating owners.
        done_delay = -2;
        plan(2, 2);
        wait_idle("alternate", 1200);

        // Stray Done during STREAM must be ignored.
        done_early = 1;
        done_delay = 15;
        plan(0, 1);
        wait_idle("early_done", 400);
        done_early = 0;

        // Random mixes.
        done_delay = -2;
        repeat (4) begin
            plan(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
            wait_idle("random_mix", 1500);
        end

        // Reset in the middle of a stream.
        rst_on();
        rst_release(2);
        done_delay = 10;
        plan(1, 0);
        hit = 1'b0;
        for (int n = 0; n < 200 && !hit; n++) begin
            @(negedge clock);
            if (vrun == 10) hit = 1'b1;
        end
        chk("reach_beat10", BW'(hit), BW'(1));
        @(posedge clock);
        #3;
        rst_on();
        chk("abort_gnt", BW'(gnt), BW'(0));
        chk("abort_valid", BW'(valid), BW'(0));
        chk("abort_beat_ack", BW'(beat_ack), BW'(0));
        chk("abort_CurByte", CurByte, BW'(0));
        chk("abort_job_done", BW'(job_done), BW'(0));
        chk("abort_busy", BW'(busy), BW'(0));
        chk("abort_comp_reset", BW'(comp_reset), BW'(1));
        plan(0, 1);
        rst_release(3);
        wait_idle("after_abort", 400);

        // No Done ever: without the watchdog the block must sit in WAIT.
        done_delay = -1;
        plan(1, 0);
        hit = 1'b0;
        for (int n = 0; n < 200 && !hit; n++) begin
            @(negedge clock);
            if (beat_q.size() == 0 && !valid) hit = 1'b1;
        end
        chk("stream_finished", BW'(hit), BW'(1));
        repeat (200) @(negedge clock);
        chk("hang_busy", BW'(busy), BW'(1));
        chk("hang_gnt", BW'(gnt), BW'(1));
        chk("hang_valid", BW'(valid), BW'(0));
        chk("hang_no_done", BW'(done_q.size()), BW'(1));
        rst_on();
        rst_release(2);
        repeat (3) @(negedge clock);
        chk("final_busy", BW'(busy), BW'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
